pixel_cache: RTL and testbench
==============================

Name: pixel_cache

Overview:
- Responder side of the pixel-request interface used by the edge searchers.
- Accepts a held (x, y) coordinate and returns the 1-bit pixel with a ready flag.
- Fetches packed 8-pixel bytes from the 1 bpp image memory (registered-output dual-port RAM) and holds them in a 2-line, fully associative byte cache with LRU replacement.
- Row-sweep and column-sweep searches then hit without re-reading memory.

Parameters:
- IMG_W, 640, image width in pixels; must be a multiple of 8.
- IMG_H, 480, image height in pixels.
- ADDR_W, 16, image memory read address width.
- RD_LATENCY, 1, cycles from rdaddress presented to rdata valid (1..3).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- x  input  10  requested pixel column; held by the requester until ready.
- y  input  10  requested pixel row; held by the requester until ready.
- pixel  output  1  pixel value; meaningful only while ready=1.
- ready  output  1  combinational; high when pixel is valid for the current x, y.
- flush  input  1  invalidates all cache lines (image memory rewritten).
- rdaddress  output  ADDR_W  registered read address to image memory.
- rdata  input  8  image memory read data.

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- Address map:
  - byte address = y*(IMG_W/8) + x[9:3], computed in ADDR_W bits.
  - bit index = x[2:0], so the LSB is the leftmost pixel of the byte (pixel (7,2) is bit 7 of byte 160; (9,4) is bit 1 of byte 321).
- Out-of-range request (x >= IMG_W or y >= IMG_H): ready=1, pixel=0 combinationally; no fetch, cache untouched.
- Each line holds: valid, tag[ADDR_W-1:0], data[7:0]. One LRU bit names the victim line.
- Hit: a valid line whose tag equals the current byte address.
  - ready=1 and pixel=data[x[2:0]] in the same cycle (combinational, zero latency).
  - A hit updates LRU to mark the hit line most recent, only while state is LOOKUP.
- While reset=1: ready=0 and pixel=0.
- Outside reset, whenever ready=0: pixel=0.
- FSM states:
  - LOOKUP: on miss (in range, no hit, flush=0), latch miss_addr=byte address, drive rdaddress<=miss_addr, clear wait counter, go to WAIT.
  - WAIT: count RD_LATENCY cycles with rdaddress held; when count reaches RD_LATENCY-1, go to FILL.
  - FILL: write rdata into the LRU victim line (valid=1, tag=miss_addr), flip LRU to point at the other line, return to LOOKUP.
- Miss timing: miss seen in cycle T → rdaddress valid in T+1 → rdata captured at the end of T+1+RD_LATENCY → ready high in T+2+RD_LATENCY (3 cycles for RD_LATENCY=1).
- x, y changing mid-fetch: the fill still completes into the victim using the latched miss_addr; hit/miss is re-evaluated in LOOKUP against the new x, y.
- Hits are still reported combinationally during WAIT/FILL (lines unchanged); LRU is not updated then.
- flush:
  - Clears all valid bits at the next edge and forces LOOKUP; an in-progress fetch is discarded.
  - flush has priority over fill in the same cycle.
  - ready is 0 during a flush cycle, except for out-of-range requests.
- Reset values: state=LOOKUP, both valid=0, LRU=0, rdaddress=0, wait counter=0. Reset mid-fetch abandons the fetch.
- rdaddress only changes on entry to WAIT, or on reset.
- The requester's REQ/WAIT retry loop means x, y may be re-presented identically every cycle; repeated misses to the same address while in WAIT/FILL do not start a second fetch.

Test Plan:
- Memory byte 160=8'h80, request (7,2) after reset → rdaddress=160 one cycle after the miss; ready=1, pixel=1 exactly 3 cycles after the request (RD_LATENCY=1); then (6,2) → ready=1, pixel=0 in the same cycle with no new fetch.
- Alternate (3,3) and (9,4) with bytes 240=8'h08 and 321=8'h02 → two misses, then both hit with pixel=1; request (0,5) (byte 400) → evicts the LRU line, and the next access to the evicted line misses again.
- Request (640,0), then (0,480) → ready=1, pixel=0 immediately; rdaddress unchanged and no state change.
- Load byte 160 and hit (7,2); write 160=8'h00 and pulse flush → the next (7,2) misses, refetches, and returns pixel=0.
- Change x from (7,2) to (3,3) during WAIT → byte 160 is filled, then a miss to 240 follows; ready is asserted only once (3,3) is resident.
- Assert reset during WAIT → ready=0; after release, valid=0, rdaddress=0, and (7,2) refetches normally; sweep with RD_LATENCY=3 → ready in T+5.

Source files
------------

// File: rtl/pixel_cache.sv
// pixel_cache: 2-line fully associative byte cache answering 1-bit pixel requests
// from a 1 bpp image memory with registered-output reads; LRU replacement.
`default_nettype none

module pixel_cache #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int ADDR_W     = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic              pixel,
   output logic              ready,
   input  logic              flush,
   output logic [ADDR_W-1:0] rdaddress,
   input  logic [7:0]        rdata
);

   typedef enum logic [1:0] {
      S_LOOKUP = 2'd0,
      S_WAIT   = 2'd1,
      S_FILL   = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(IMG_W / 8);
   localparam logic [10:0]       IMG_W_L    = 11'(IMG_W);
   localparam logic [10:0]       IMG_H_L    = 11'(IMG_H);
   localparam logic [1:0]        LAT_M1     = 2'(RD_LATENCY - 1);

   state_t            state_q, state_d;
   logic [1:0]        valid_q, valid_d;
   logic [ADDR_W-1:0] tag_q  [2];
   logic [ADDR_W-1:0] tag_d  [2];
   logic [7:0]        data_q [2];
   logic [7:0]        data_d [2];
   logic              lru_q, lru_d;
   logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
   logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
   logic [1:0]        cnt_q, cnt_d;

   logic [ADDR_W-1:0] byte_addr;
   logic              in_range;
   logic [1:0]        hit_vec;
   logic              hit;
   logic              hit_way;
   logic [7:0]        hit_data;

   assign byte_addr = ADDR_W'(y) * LINE_BYTES + ADDR_W'(x[9:3]);
   assign in_range  = ({1'b0, x} < IMG_W_L) && ({1'b0, y} < IMG_H_L);
   assign hit_vec[0] = valid_q[0] && (tag_q[0] == byte_addr);
   assign hit_vec[1] = valid_q[1] && (tag_q[1] == byte_addr);
   assign hit       = |hit_vec;
   assign hit_way   = hit_vec[1];
   assign hit_data  = hit_way ? data_q[1] : data_q[0];

   // A flush cycle never reports a hit: the lines are about to be dropped.
   assign ready     = !reset && (!in_range || (!flush && hit));
   assign pixel     = ready && in_range && hit_data[x[2:0]];
   assign rdaddress = rdaddress_q;

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      lru_d       = lru_q;
      miss_addr_d = miss_addr_q;
      rdaddress_d = rdaddress_q;
      cnt_d       = cnt_q;
      if (flush) begin
         valid_d = 2'b00;
         state_d = S_LOOKUP;
      end else begin
         case (state_q)
            S_LOOKUP: begin
               if (in_range && !hit) begin
                  miss_addr_d = byte_addr;
                  rdaddress_d = byte_addr;
                  cnt_d       = 2'd0;
                  state_d     = S_WAIT;
               end else if (in_range && hit) begin
                  // LRU names the victim, so point it at the line not just used.
                  lru_d = !hit_way;
               end
            end
            S_WAIT: begin
               if (cnt_q == LAT_M1) begin
                  state_d = S_FILL;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            S_FILL: begin
               valid_d[lru_q] = 1'b1;
               tag_d[lru_q]   = miss_addr_q;
               data_d[lru_q]  = rdata;
               lru_d          = !lru_q;
               state_d        = S_LOOKUP;
            end
            default: state_d = S_LOOKUP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LOOKUP;
         valid_q     <= 2'b00;
         tag_q       <= '{default: '0};
         data_q      <= '{default: '0};
         lru_q       <= 1'b0;
         miss_addr_q <= '0;
         rdaddress_q <= '0;
         cnt_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
         lru_q       <= lru_d;
         miss_addr_q <= miss_addr_d;
         rdaddress_q <= rdaddress_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pixel_cache.sv
// tb_pixel_cache: cycle-by-cycle vector table plus directed corner sequences,
// with a latency-1 and a latency-3 instance sharing one image memory model.
`default_nettype none

module tb_pixel_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  x, y;
   logic        flush;
   logic        pixel1, ready1, pixel3, ready3;
   logic [15:0] rda1, rda3;
   logic [7:0]  rdata1, rdata3;

   logic [7:0]  mem [0:65535];
   logic [7:0]  p1;
   logic [7:0]  q3 [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      p1    <= mem[rda1];
      q3[0] <= mem[rda3];
      q3[1] <= q3[0];
      q3[2] <= q3[1];
   end
   assign rdata1 = p1;
   assign rdata3 = q3[2];

   pixel_cache #(.IMG_W(640), .IMG_H(480), .ADDR_W(16), .RD_LATENCY(1)) u_dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .pixel(pixel1), .ready(ready1),
      .flush(flush), .rdaddress(rda1), .rdata(rdata1)
   );

   pixel_cache #(.IMG_W(640), .IMG_H(480), .ADDR_W(16), .RD_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .x(x), .y(y), .pixel(pixel3), .ready(ready3),
      .flush(flush), .rdaddress(rda3), .rdata(rdata3)
   );

   typedef struct {
      logic [9:0]  vx;
      logic [9:0]  vy;
      logic        vfl;
      logic        er;
      logic        ep;
      logic [15:0] ea;
   } vec_t;

   localparam int NV = 31;
   vec_t tbl [NV];

   task automatic setv(input int i, input int vx, input int vy, input bit vfl,
                       input bit er, input bit ep, input int ea);
      tbl[i].vx  = 10'(vx);
      tbl[i].vy  = 10'(vy);
      tbl[i].vfl = vfl;
      tbl[i].er  = er;
      tbl[i].ep  = ep;
      tbl[i].ea  = 16'(ea);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge; outputs are checked at the negedge.
   task automatic cyc(input int vx, input int vy, input bit vfl);
      @(posedge clk);
      #1;
      x     = 10'(vx);
      y     = 10'(vy);
      flush = vfl;
      @(negedge clk);
   endtask

   task automatic exp1(input string name, input bit er, input bit ep);
      chk({name, " ready"}, 32'(ready1), 32'(er));
      chk({name, " pixel"}, 32'(pixel1), 32'(ep));
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[160] = 8'h80;
      mem[240] = 8'h08;
      mem[321] = 8'h02;
      mem[400] = 8'h01;

      setv( 0,   7,   2, 0, 0, 0,   0);
      setv( 1,   7,   2, 0, 0, 0, 160);
      setv( 2,   7,   2, 0, 0, 0, 160);
      setv( 3,   7,   2, 0, 1, 1, 160);
      setv( 4,   6,   2, 0, 1, 0, 160);
      setv( 5,   3,   3, 0, 0, 0, 160);
      setv( 6,   3,   3, 0, 0, 0, 240);
      setv( 7,   3,   3, 0, 0, 0, 240);
      setv( 8,   3,   3, 0, 1, 1, 240);
      setv( 9,   9,   4, 0, 0, 0, 240);
      setv(10,   9,   4, 0, 0, 0, 321);
      setv(11,   9,   4, 0, 0, 0, 321);
      setv(12,   9,   4, 0, 1, 1, 321);
      setv(13,   3,   3, 0, 1, 1, 321);
      setv(14,   9,   4, 0, 1, 1, 321);
      setv(15,   0,   5, 0, 0, 0, 321);
      setv(16,   0,   5, 0, 0, 0, 400);
      setv(17,   0,   5, 0, 0, 0, 400);
      setv(18,   0,   5, 0, 1, 1, 400);
      setv(19,   3,   3, 0, 0, 0, 400);
      setv(20,   3,   3, 0, 0, 0, 240);
      setv(21,   3,   3, 0, 0, 0, 240);
      setv(22,   3,   3, 0, 1, 1, 240);
      setv(23, 640,   0, 0, 1, 0, 240);
      setv(24,   0, 480, 0, 1, 0, 240);
      setv(25,   0,   5, 0, 1, 1, 240);
      setv(26,   0,   5, 1, 0, 0, 240);
      setv(27,   0,   5, 0, 0, 0, 240);
      setv(28,   0,   5, 0, 0, 0, 400);
      setv(29,   0,   5, 0, 0, 0, 400);
      setv(30,   0,   5, 0, 1, 1, 400);

      reset = 1'b1;
      x     = 10'd7;
      y     = 10'd2;
      flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      exp1("in reset", 1'b0, 1'b0);
      chk("reset rdaddress", 32'(rda1), 32'd0);

      // Release reset on an out-of-range request so nothing is fetched yet.
      @(posedge clk);
      #1;
      reset = 1'b0;
      x     = 10'd640;
      y     = 10'd0;
      @(negedge clk);
      exp1("release oor", 1'b1, 1'b0);
      chk("release rdaddress", 32'(rda1), 32'd0);

      for (int i = 0; i < NV; i++) begin
         cyc(int'(tbl[i].vx), int'(tbl[i].vy), tbl[i].vfl);
         chk($sformatf("vec%0d ready", i), 32'(ready1), 32'(tbl[i].er));
         chk($sformatf("vec%0d pixel", i), 32'(pixel1), 32'(tbl[i].ep));
         chk($sformatf("vec%0d rdaddress", i), 32'(rda1), 32'(tbl[i].ea));
      end

      // Request moves from (7,2) to (3,3) while 160 is being fetched.
      cyc(7, 2, 0); exp1("mid miss", 1'b0, 1'b0);
      cyc(3, 3, 0); exp1("mid wait", 1'b0, 1'b0);
      chk("mid rdaddress 160", 32'(rda1), 32'd160);
      cyc(3, 3, 0); exp1("mid fill", 1'b0, 1'b0);
      cyc(3, 3, 0); exp1("mid second miss", 1'b0, 1'b0);
      cyc(3, 3, 0); exp1("mid wait2", 1'b0, 1'b0);
      chk("mid rdaddress 240", 32'(rda1), 32'd240);
      cyc(3, 3, 0); exp1("mid fill2", 1'b0, 1'b0);
      cyc(3, 3, 0); exp1("mid hit 240", 1'b1, 1'b1);
      cyc(7, 2, 0); exp1("mid hit 160", 1'b1, 1'b1);

      // Memory rewritten, then flushed: the stale byte must be refetched.
      mem[160] = 8'h00;
      cyc(7, 2, 1); exp1("flush cycle", 1'b0, 1'b0);
      cyc(7, 2, 0); exp1("post flush miss", 1'b0, 1'b0);
      cyc(7, 2, 0); exp1("refetch wait", 1'b0, 1'b0);
      cyc(7, 2, 0); exp1("refetch fill", 1'b0, 1'b0);
      cyc(7, 2, 0); exp1("refetch new data", 1'b1, 1'b0);
      mem[160] = 8'h80;

      // Reset while a fetch is in flight, then a fresh sweep on both latencies.
      cyc(100, 100, 0); exp1("pre reset miss", 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      exp1("reset in wait", 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      x     = 10'd7;
      y     = 10'd2;
      @(negedge clk);
      exp1("after reset miss", 1'b0, 1'b0);
      chk("after reset rdaddress", 32'(rda1), 32'd0);
      chk("after reset rdaddress lat3", 32'(rda3), 32'd0);
      chk("after reset ready lat3", 32'(ready3), 32'd0);
      cyc(7, 2, 0);
      chk("T+1 rdaddress", 32'(rda1), 32'd160);
      chk("T+1 rdaddress lat3", 32'(rda3), 32'd160);
      cyc(7, 2, 0); exp1("T+2", 1'b0, 1'b0);
      cyc(7, 2, 0); exp1("T+3", 1'b1, 1'b1);
      chk("T+3 ready lat3", 32'(ready3), 32'd0);
      cyc(7, 2, 0);
      chk("T+4 ready lat3", 32'(ready3), 32'd0);
      chk("T+4 pixel lat3", 32'(pixel3), 32'd0);
      cyc(7, 2, 0);
      chk("T+5 ready lat3", 32'(ready3), 32'd1);
      chk("T+5 pixel lat3", 32'(pixel3), 32'd1);
      cyc(6, 2, 0);
      chk("lat3 neighbour ready", 32'(ready3), 32'd1);
      chk("lat3 neighbour pixel", 32'(pixel3), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
